// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared opcode and FSM state encodings for the multiply sequencer
package mul_seq_pkg;
  localparam logic [3:0] INST_MUL = 4'h5;
  localparam int MUL_WIDTH = 16;
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: decode-side request and writeback bundle of the multiply sequencer
interface mul_seq_if #(parameter int WIDTH = 16);
  logic start;
  logic flush;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [3:0] rdIdx;
  logic stall;
  logic busy;
  logic wbEn;
  logic [3:0] wbIdx;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] resultHi;
  logic zFlag;
  modport master (
    output start, flush, opA, opB, rdIdx,
    input stall, busy, wbEn, wbIdx, result, resultHi, zFlag
  );
  modport slave (
    input start, flush, opA, opB, rdIdx,
    output stall, busy, wbEn, wbIdx, result, resultHi, zFlag
  );
endinterface

// File: rtl/mul_dp.sv
// mul_dp: shift-add datapath (acc/mcand/mplr); MUL_EARLY_TERM_EN adds the mplr_empty flag
module mul_dp #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
`ifdef MUL_EARLY_TERM_EN
  output logic               mplr_empty,
`endif
  output logic [2*WIDTH-1:0] acc
);
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
`ifdef MUL_EARLY_TERM_EN
  // multiplier is exhausted once the bits left after this cycle's shift are all zero
  assign mplr_empty = mplr[WIDTH-1:1] == '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, op_a};
      mplr  <= op_b;
    end else if (step) begin
      if (mplr[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
    end
  end
endmodule

// File: rtl/mul_seq.sv
// mul_seq: radix-2 multiply sequencer with stall/flush/writeback; MUL_EARLY_TERM_EN enables early exit
module mul_seq import mul_seq_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic      clk,
  input logic      reset,
  mul_seq_if.slave bus
);
  mul_state_t         state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         wb_idx;
  logic [2*WIDTH-1:0] acc;
  logic               accept, last;
`ifdef MUL_EARLY_TERM_EN
  logic mplr_empty;
  assign last = cnt == CNT_W'(WIDTH - 1) || mplr_empty;
`else
  assign last = cnt == CNT_W'(WIDTH - 1);
`endif
  mul_dp #(.WIDTH(WIDTH)) dp (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .step       (state == MUL_RUN),
    .op_a       (bus.opA),
    .op_b       (bus.opB),
`ifdef MUL_EARLY_TERM_EN
    .mplr_empty (mplr_empty),
`endif
    .acc        (acc)
  );
  always_comb begin
    accept   = bus.start && !bus.flush && (state == MUL_IDLE || state == MUL_DONE);
    state_nx = bus.flush ? MUL_IDLE :
               accept ? MUL_RUN :
               state == MUL_RUN ? (last ? MUL_DONE : MUL_RUN) : MUL_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      wb_idx <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt    <= '0;
        wb_idx <= bus.rdIdx;
      end else if (state == MUL_RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.busy     = state == MUL_RUN;
  assign bus.stall    = accept || bus.busy;
  assign bus.wbEn     = state == MUL_DONE && !bus.flush;
  assign bus.wbIdx    = wb_idx;
  assign bus.result   = acc[WIDTH-1:0];
  assign bus.resultHi = acc[2*WIDTH-1:WIDTH];
  assign bus.zFlag    = bus.wbEn && acc[WIDTH-1:0] == '0;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq; writeback timing/value model follows MUL_EARLY_TERM_EN
module tb_mul_seq;
  typedef struct {
    logic [3:0]  idx;
    logic [31:0] prod;
    int          cyc;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic acc_stall;
  exp_t sb[$];
  exp_t e;
  mul_seq_if #(.WIDTH(16)) bus ();
  mul_seq #(.WIDTH(16), .CNT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int lat(input logic [15:0] b);
`ifdef MUL_EARLY_TERM_EN
    int r = 1;
    for (int i = 0; i < 16; i++) if (b[i]) r = i + 1;
    return r + 1;
`else
    return 17;
`endif
  endfunction
  always @(negedge clk) begin
    if (!reset && bus.wbEn) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: wbEn=1 at cycle %0d, required no writeback", cyc);
      end else begin
        e = sb.pop_front();
        if ({bus.resultHi, bus.result} !== e.prod || bus.zFlag !== (e.prod[15:0] == 16'h0) ||
            bus.wbIdx !== e.idx || cyc != e.cyc) begin
          errors++;
          $display("FAIL wb_data: got prod=%h z=%b idx=%h cyc=%0d, required prod=%h z=%b idx=%h cyc=%0d",
                   {bus.resultHi, bus.result}, bus.zFlag, bus.wbIdx, cyc,
                   e.prod, e.prod[15:0] == 16'h0, e.idx, e.cyc);
        end
      end
    end
  end
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] idx);
    @(posedge clk); #1;
    bus.start = 1; bus.opA = a; bus.opB = b; bus.rdIdx = idx;
    sb.push_back('{idx, 32'(a) * 32'(b), cyc + lat(b)});
    @(negedge clk);
    acc_stall = bus.stall;
    @(posedge clk); #1;
    bus.start = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.busy, bus.wbEn, bus.wbIdx, bus.result, bus.resultHi, bus.zFlag} !== 40'h0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h required 0",
               {bus.stall, bus.busy, bus.wbEn, bus.wbIdx, bus.result, bus.resultHi, bus.zFlag});
    end
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.busy, bus.wbEn, bus.wbIdx, bus.result, bus.resultHi, bus.zFlag} !== 40'h0) begin
      errors++;
      $display("FAIL reset_release: outputs=%h required 0",
               {bus.stall, bus.busy, bus.wbEn, bus.wbIdx, bus.result, bus.resultHi, bus.zFlag});
    end
  endtask
  task automatic test_basic();
    issue(16'd3, 16'd5, 4'd7);
    checks++;
    if (acc_stall !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept_stall: stall=%b required 1", acc_stall);
    end
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: pending=%0d required 0", sb.size());
    end
  endtask
  task automatic test_stall();
    issue(16'hFFFF, 16'hFFFF, 4'hC);
    checks++;
    if (acc_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_accept: stall=%b required 1", acc_stall);
    end
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      checks++;
      if (bus.stall !== (k <= 16) || bus.busy !== (k <= 16)) begin
        errors++;
        $display("FAIL stall_k%0d: stall=%b busy=%b required %b", k, bus.stall, bus.busy, k <= 16);
      end
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: pending=%0d required 0", sb.size());
    end
  endtask
  task automatic test_flush();
    issue(16'h1234, 16'h8001, 4'd3);
    repeat (3) @(posedge clk);
    @(posedge clk); #1 bus.flush = 1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (bus.wbEn !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle: wbEn=%b busy=%b required 0 1", bus.wbEn, bus.busy);
    end
    @(posedge clk); #1 bus.flush = 0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b stall=%b required 0 0", bus.busy, bus.stall);
    end
    repeat (25) @(negedge clk);
    @(posedge clk); #1 bus.start = 1; bus.flush = 1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_same: stall=%b required 0", bus.stall);
    end
    @(posedge clk); #1 bus.start = 0; bus.flush = 0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_busy: busy=%b required 0", bus.busy);
    end
    repeat (20) @(negedge clk);
  endtask
  task automatic test_done_flush();
    issue(16'hFFFF, 16'hFFFF, 4'hA);
    repeat (15) @(posedge clk);
    @(posedge clk); #1 bus.flush = 1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (bus.wbEn !== 1'b0 || bus.zFlag !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_flush: wbEn=%b zFlag=%b busy=%b required 0 0 0", bus.wbEn, bus.zFlag, bus.busy);
    end
    @(posedge clk); #1 bus.flush = 0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL done_flush_idle: busy=%b stall=%b required 0 0", bus.busy, bus.stall);
    end
    repeat (5) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    issue(16'hFFFF, 16'hFFFF, 4'd1);
    repeat (15) @(posedge clk);
    issue(16'd2, 16'd4, 4'd2);
    checks++;
    if (acc_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_stall: stall=%b required 1", acc_stall);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_bubble: busy=%b required 1", bus.busy);
    end
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: pending=%0d required 0", sb.size());
    end
  endtask
  task automatic test_reset_midrun();
    issue(16'h00FF, 16'h8003, 4'd5);
    repeat (6) @(posedge clk);
    @(posedge clk); #1 reset = 1;
    sb.delete();
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.busy, bus.wbEn, bus.wbIdx, bus.result, bus.resultHi, bus.zFlag} !== 40'h0) begin
      errors++;
      $display("FAIL reset_midrun: outputs=%h required 0",
               {bus.stall, bus.busy, bus.wbEn, bus.wbIdx, bus.result, bus.resultHi, bus.zFlag});
    end
    issue(16'd9, 16'd9, 4'd6);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_restart_drain: pending=%0d required 0", sb.size());
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      issue(16'($urandom), 16'($urandom), 4'($urandom));
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL random_drain%0d: pending=%0d required 0", n, sb.size());
      end
    end
  endtask
`ifdef MUL_EARLY_TERM_EN
  task automatic test_early_term();
    issue(16'd7, 16'd2, 4'd1);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    issue(16'd5, 16'd0, 4'd2);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL early_drain: pending=%0d required 0", sb.size());
    end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 0; bus.flush = 0; bus.opA = '0; bus.opB = '0; bus.rdIdx = '0;
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_done_flush();
    test_back_to_back();
    test_reset_midrun();
    test_random();
`ifdef MUL_EARLY_TERM_EN
    test_early_term();
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard: pending=%0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer for SimpleCore's `INST_MUL` instructions, implemented as a radix-2 shift-add multiplier. It sits beside the ALU in the execute stage and takes operands and destination index from the decode/register-read outputs. While a product is being formed it stalls fetch/decode, then issues a one-cycle writeback. It honours pipeline flush so a multiply on a mispredicted path never writes back.

## Interface
- `WIDTH`, 16, operand width; product is 2×`WIDTH`.
- `CNT_W`, 5, iteration counter width; must satisfy 2^`CNT_W` > `WIDTH`.

- `clk`  in  1  main clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  decode presents a valid `INST_MUL` (not refill).
- `flush`  in  1  pipeline flush; aborts any multiply in progress.
- `opA`  in  `WIDTH`  multiplicand (Rs1 value).
- `opB`  in  `WIDTH`  multiplier (Rs2 value).
- `rdIdx`  in  4  destination register index.
- `stall`  out  1  hold fetch/decode.
- `busy`  out  1  state is RUN.
- `wbEn`  out  1  one-cycle writeback strobe.
- `wbIdx`  out  4  latched destination index.
- `result`  out  `WIDTH`  product bits [`WIDTH`-1:0].
- `resultHi`  out  `WIDTH`  product bits [2×`WIDTH`-1:`WIDTH`].
- `zFlag`  out  1  `result` == 0; valid when `wbEn` is high.

## Operation
- States: IDLE, RUN, DONE.
- Start is accepted when `start` && !`flush` && state ∈ {IDLE, DONE}. On acceptance:
  - latch `mcand` (2×`WIDTH`, zero-extended `opA`), `mplr` = `opB`, `wbIdx` = `rdIdx`;
  - clear `acc` and `cnt`;
  - go to RUN.
- Each RUN cycle:
  - if `mplr`[0], then `acc` += `mcand` (2×`WIDTH` bits, carry-out discarded);
  - `mcand` <<= 1; `mplr` >>= 1; `cnt`++.
- RUN → DONE on the cycle in which `cnt` reaches `WIDTH`-1 (the last iteration).
- DONE:
  - `wbEn` = 1; `result`/`resultHi` = `acc`;
  - next state is RUN if a start is accepted, else IDLE.
- `start` while in RUN is ignored. This cannot occur legally because `stall` is high.
- `flush` in RUN or DONE forces IDLE next cycle. `wbEn` is suppressed in a DONE cycle that coincides with `flush`.
- `flush` with `start` in the same cycle: flush wins, nothing accepted.
- Unsigned multiply only. The low half equals the two's-complement low half for signed operands.
- `reset`: state IDLE; `acc`, `mcand`, `mplr`, `cnt`, `wbIdx` = 0. All outputs then read 0.

## Timing
- Start accepted in cycle n:
  - RUN in cycles n+1..n+`WIDTH`;
  - DONE (`wbEn`) in cycle n+`WIDTH`+1 (n+17 at default).
- `stall` = accepted-start (combinational, cycle n) | (state == RUN).
- `stall` is low in DONE, so the pipeline advances in the writeback cycle.
- Back-to-back: a start accepted in DONE enters RUN the next cycle with zero bubble.
- `result`, `resultHi`, `zFlag` are registered or decoded from `acc`; they are stable throughout DONE.

## Configuration
- `MUL_EARLY_TERM_EN` defined:
  - RUN → DONE also when the post-shift `mplr` == 0;
  - latency is 1 + position of the highest set bit of `opB`;
  - `opB` = 0 takes one RUN cycle.
- Undefined: always exactly `WIDTH` RUN cycles; the early-exit logic is absent.

## Structure
- Shared defines header holds `INST_MUL` and the state encodings `MUL_IDLE`/`MUL_RUN`/`MUL_DONE` (2 bits).
- One sub-module, `mul_dp`: the `acc`/`mcand`/`mplr` registers, adder and shifters, with `load`/`step` controls.
- The FSM, counter and handshake logic stay in `mul_seq`.

## Test plan
- opA=3, opB=5, start at cycle n → `wbEn` at n+17, `result`=0x000F, `resultHi`=0, `zFlag`=0, `wbIdx`=`rdIdx`.
- opA=0xFFFF, opB=0xFFFF → `result`=0x0001, `resultHi`=0xFFFE; `stall` high n..n+16, low at n+17.
- Start, then `flush` at n+5 → state IDLE at n+6, `stall` low, no `wbEn` ever; `flush`+`start` same cycle → no acceptance.
- Second start asserted in the DONE cycle (opA=2, opB=4) → first writeback at n+17, second at n+34, no idle cycle between.
- `reset` at n+8 mid-run → IDLE at n+9, all outputs 0, no `wbEn`; fresh start afterwards completes normally.
- With `MUL_EARLY_TERM_EN`: opA=7, opB=2 → `wbEn` at n+3, `result`=14; opB=0 → `wbEn` at n+2, `result`=0, `zFlag`=1.
